// File: rtl/e203_dtcm_pkg.sv
// Shared definitions for the banked DTCM array.
// Holds the power-mode and power-FSM state encodings plus a constant clog2
// helper used to size the bank and row address fields.
package e203_dtcm_pkg;

  typedef enum logic [1:0] {
    PWR_ACT = 2'b00,
    PWR_LS  = 2'b01,
    PWR_DS  = 2'b10,
    PWR_SD  = 2'b11
  } pwr_mode_e;

  typedef enum logic [1:0] {
    ST_ACT  = 2'b00,
    ST_LOWP = 2'b01,
    ST_WAKE = 2'b10
  } pwr_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/e203_dtcm_pwr_ctrl.sv
// Power sequencer for the banked DTCM.
// Ports: clk/rst_n, pwr_req requested mode, pipe_busy (read in flight),
// ready (accesses allowed), pwr_ack (requested low-power mode reached),
// ls/ds/sd per-bank low-power pins (all banks driven identically).
module e203_dtcm_pwr_ctrl
  import e203_dtcm_pkg::*;
#(
  parameter int unsigned BANKS    = 2,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pwr_req,
  input  logic             pipe_busy,
  output logic             ready,
  output logic             pwr_ack,
  output logic [BANKS-1:0] ls,
  output logic [BANKS-1:0] ds,
  output logic [BANKS-1:0] sd
);

  pwr_state_e state;
  pwr_mode_e  mode;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ACT;
      mode    <= PWR_ACT;
      cnt     <= '0;
      pwr_ack <= 1'b0;
      ls      <= '0;
      ds      <= '0;
      sd      <= '0;
    end else begin
      unique case (state)
        ST_ACT: begin
          // Entry waits until any accepted read has produced its response.
          if ((pwr_req != PWR_ACT) && !pipe_busy) begin
            state   <= ST_LOWP;
            mode    <= pwr_mode_e'(pwr_req);
            pwr_ack <= 1'b1;
            ls      <= {BANKS{pwr_req == PWR_LS}};
            ds      <= {BANKS{pwr_req == PWR_DS}};
            sd      <= {BANKS{pwr_req == PWR_SD}};
          end
        end
        ST_LOWP: begin
          if (pwr_req != mode) begin
            state   <= ST_WAKE;
            pwr_ack <= 1'b0;
            ls      <= '0;
            ds      <= '0;
            sd      <= '0;
            cnt     <= 4'(WAKE_CYC);
          end
        end
        ST_WAKE: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_ACT;
        end
        default: state <= ST_ACT;
      endcase
    end
  end

  assign ready = (state == ST_ACT) && (pwr_req == PWR_ACT);

endmodule

// File: rtl/sirv_gnrl_ram.sv
// Behavioural single-port SRAM macro model.
// Ports: clk/rst_n, ls/ds/sd low-power pins, cs/we access strobe, addr row
// address, wem byte-group write mask, din write data, dout registered read
// data (one-cycle latency, updated only by reads).
module sirv_gnrl_ram #(
  parameter int unsigned DP           = 8192,
  parameter int unsigned DW           = 32,
  parameter int unsigned MW           = 4,
  parameter int unsigned AW           = 13,
  parameter bit          FORCE_X2ZERO = 1'b1
) (
  input  logic          sd,
  input  logic          ds,
  input  logic          ls,
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [MW-1:0] wem,
  output logic [DW-1:0] dout
);

  localparam int unsigned GW = DW / MW;

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] q;
  logic          awake;

  assign awake = ~(sd | ds | ls);

  always_ff @(posedge clk) begin
    if (cs && we && awake) begin
      for (int unsigned i = 0; i < MW; i++) begin
        if (wem[i]) mem[addr][i*GW +: GW] <= din[i*GW +: GW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (cs && !we && awake) q <= mem[addr];
  end

  // Unwritten locations read as X in 4-state simulation; force those bits to 0
  // so they cannot poison the downstream response mux.
  always_comb begin
    dout = q;
    if (FORCE_X2ZERO) begin
      for (int unsigned i = 0; i < DW; i++) begin
        if (q[i] === 1'bx) dout[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/e203_dtcm_bankram.sv
// Multi-bank DTCM SRAM array with low-order word interleave.
// Ports: clk/rst_n, cs/we/addr/wem/din access request (taken when ready=1),
// ready, dout/rsp_vld read response, pwr_req/pwr_ack low-power handshake.
module e203_dtcm_bankram
  import e203_dtcm_pkg::*;
#(
  parameter int unsigned BANKS    = 2,
  parameter int unsigned DP       = 16384,
  parameter int unsigned DW       = 32,
  parameter int unsigned MW       = 4,
  parameter int unsigned AW       = 14,
  parameter int unsigned OUT_REG  = 0,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [MW-1:0] wem,
  input  logic [DW-1:0] din,
  output logic          ready,
  output logic [DW-1:0] dout,
  output logic          rsp_vld,
  input  logic [1:0]    pwr_req,
  output logic          pwr_ack
);

  localparam int unsigned BW  = clog2(BANKS);
  localparam int unsigned BIW = (BW == 0) ? 1 : BW;
  localparam int unsigned RW  = AW - BW;
  localparam int unsigned BDP = DP / BANKS;

  logic             accept;
  logic             rd_acc;
  logic [BIW-1:0]   bank_sel;
  logic [RW-1:0]    row;
  logic [BANKS-1:0] bank_ls, bank_ds, bank_sd;
  logic [DW-1:0]    bank_dout [BANKS];
  logic             vld1;
  logic [BIW-1:0]   bank1;
  logic [DW-1:0]    rd_data;
  logic             pipe_busy;

  assign accept = cs & ready;
  assign rd_acc = accept & ~we;

  if (BANKS > 1) begin : g_split
    assign bank_sel = addr[BW-1:0];
    assign row      = addr[AW-1:BW];
  end else begin : g_nosplit
    assign bank_sel = '0;
    assign row      = addr;
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    sirv_gnrl_ram #(
      .DP           (BDP),
      .DW           (DW),
      .MW           (MW),
      .AW           (RW),
      .FORCE_X2ZERO (1'b1)
    ) u_ram (
      .sd    (bank_sd[b]),
      .ds    (bank_ds[b]),
      .ls    (bank_ls[b]),
      .rst_n (rst_n),
      .clk   (clk),
      .cs    (accept && (bank_sel == BIW'(b))),
      .we    (we),
      .addr  (row),
      .din   (din),
      .wem   (wem),
      .dout  (bank_dout[b])
    );
  end

  // The bank macros keep their read register until the next read, but the
  // response mux must follow the bank of the read that is returning now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1  <= 1'b0;
      bank1 <= '0;
    end else begin
      vld1 <= rd_acc;
      if (rd_acc) bank1 <= bank_sel;
    end
  end

  assign rd_data = bank_dout[bank1];

  if (OUT_REG != 0) begin : g_oreg
    logic          vld2;
    logic [DW-1:0] dout2;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld2  <= 1'b0;
        dout2 <= '0;
      end else begin
        vld2 <= vld1;
        if (vld1) dout2 <= rd_data;
      end
    end
    assign rsp_vld   = vld2;
    assign dout      = dout2;
    assign pipe_busy = vld1 | vld2;
  end else begin : g_noreg
    // Hold register keeps dout stable between responses without adding latency.
    logic [DW-1:0] hold;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold <= '0;
      else if (vld1) hold <= rd_data;
    end
    assign rsp_vld   = vld1;
    assign dout      = vld1 ? rd_data : hold;
    assign pipe_busy = vld1;
  end

  e203_dtcm_pwr_ctrl #(
    .BANKS    (BANKS),
    .WAKE_CYC (WAKE_CYC)
  ) u_pwr (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_req   (pwr_req),
    .pipe_busy (pipe_busy),
    .ready     (ready),
    .pwr_ack   (pwr_ack),
    .ls        (bank_ls),
    .ds        (bank_ds),
    .sd        (bank_sd)
  );

endmodule

// File: tb/tb_e203_dtcm_bankram.sv
// Directed self-checking bench for e203_dtcm_bankram.
// u0 uses OUT_REG=0, u1 uses OUT_REG=1; both share the same stimulus.
module tb_e203_dtcm_bankram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [13:0] addr = '0;
  logic [3:0]  wem = '0;
  logic [31:0] din = '0;
  logic [1:0]  pwr_req = 2'b00;

  logic        ready0, rsp_vld0, pwr_ack0;
  logic [31:0] dout0;
  logic        ready1, rsp_vld1, pwr_ack1;
  logic [31:0] dout1;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;
  int unsigned nproto = 0;

  always #5 clk = ~clk;

  e203_dtcm_bankram #(.OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wem(wem),
    .din(din), .ready(ready0), .dout(dout0), .rsp_vld(rsp_vld0),
    .pwr_req(pwr_req), .pwr_ack(pwr_ack0)
  );

  e203_dtcm_bankram #(.OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wem(wem),
    .din(din), .ready(ready1), .dout(dout1), .rsp_vld(rsp_vld1),
    .pwr_req(pwr_req), .pwr_ack(pwr_ack1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; we = 1'b1; addr = a; din = d; wem = m;
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_rsp_vld", {31'd0, rsp_vld0}, 32'd0);
    chk("rst_dout", dout0, 32'd0);
    chk("rst_pwr_ack", {31'd0, pwr_ack0}, 32'd0);
    chk("rst_pins", {26'd0, u0.bank_ls, u0.bank_ds, u0.bank_sd}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Interleave across banks
    wr(14'd0, 32'h1111_1111, 4'hF);
    wr(14'd1, 32'h2222_2222, 4'hF);
    wr(14'd2, 32'h3333_3333, 4'hF);
    wr(14'd7, 32'h7777_7777, 4'hF);
    cs = 1'b1; we = 1'b0; addr = 14'd0;
    #1 chk("il_first_no_rsp", {31'd0, rsp_vld0}, 32'd0);
    cyc(); addr = 14'd1;
    #1 chk("il_vld0", {31'd0, rsp_vld0}, 32'd1);
    chk("il_dout0", dout0, 32'h1111_1111);
    cyc(); addr = 14'd2;
    #1 chk("il_vld1", {31'd0, rsp_vld0}, 32'd1);
    chk("il_dout1", dout0, 32'h2222_2222);
    cyc(); cs = 1'b0;
    #1 chk("il_vld2", {31'd0, rsp_vld0}, 32'd1);
    chk("il_dout2", dout0, 32'h3333_3333);
    cyc();
    #1 chk("il_idle_vld", {31'd0, rsp_vld0}, 32'd0);
    chk("il_hold_dout", dout0, 32'h3333_3333);
    cyc(); cyc();

    // Output-register latency
    cs = 1'b1; we = 1'b0; addr = 14'd0;
    #1 chk("oreg_n", {31'd0, rsp_vld1}, 32'd0);
    cyc(); cs = 1'b0;
    #1 chk("oreg_n1", {31'd0, rsp_vld1}, 32'd0);
    cyc();
    #1 chk("oreg_n2_vld", {31'd0, rsp_vld1}, 32'd1);
    chk("oreg_n2_dout", dout1, 32'h1111_1111);
    cyc();
    #1 chk("oreg_n3", {31'd0, rsp_vld1}, 32'd0);
    cyc();

    // Write mask
    wr(14'd5, 32'hAABB_CCDD, 4'b1111);
    wr(14'd5, 32'h0000_0011, 4'b0001);
    cs = 1'b1; we = 1'b0; addr = 14'd5;
    cyc(); cs = 1'b0;
    #1 chk("mask_dout", dout0, 32'hAABB_CC11);
    cyc(); cyc();

    // Light-sleep entry delayed by an in-flight read
    cs = 1'b1; we = 1'b0; addr = 14'd0;
    cyc(); cs = 1'b0; pwr_req = 2'b01;
    #1 chk("ls_ready_n1", {31'd0, ready0}, 32'd0);
    chk("ls_rsp_n1", {31'd0, rsp_vld0}, 32'd1);
    chk("ls_ack_n1", {31'd0, pwr_ack0}, 32'd0);
    cyc();
    #1 chk("ls_ack_n2", {31'd0, pwr_ack0}, 32'd0);
    cyc();
    #1 chk("ls_ack_n3", {31'd0, pwr_ack0}, 32'd1);
    chk("ls_pins", {26'd0, u0.bank_ls, u0.bank_ds, u0.bank_sd}, {26'd0, 2'b11, 2'b00, 2'b00});

    // Accesses while not ready are ignored
    $display("note: driving cs while ready=0 (deliberate protocol error)");
    nproto++;
    cs = 1'b1; we = 1'b1; addr = 14'd7; din = 32'hDEAD_BEEF; wem = 4'hF;
    cyc(); we = 1'b0;
    #1 chk("ign_wr_rsp", {31'd0, rsp_vld0}, 32'd0);
    chk("ign_ack", {31'd0, pwr_ack0}, 32'd1);
    nproto++;
    cyc(); cs = 1'b0;
    #1 chk("ign_rd_rsp", {31'd0, rsp_vld0}, 32'd0);

    // Wake sequence
    pwr_req = 2'b00;
    cyc();
    #1 chk("wk1_ready", {31'd0, ready0}, 32'd0);
    chk("wk1_ack", {31'd0, pwr_ack0}, 32'd0);
    chk("wk1_ls", {30'd0, u0.bank_ls}, 32'd0);
    cyc();
    #1 chk("wk2_ready", {31'd0, ready0}, 32'd0);
    cyc();
    #1 chk("wk3_ready", {31'd0, ready0}, 32'd1);

    // Retention and ignored write
    cs = 1'b1; we = 1'b0; addr = 14'd0;
    cyc(); addr = 14'd7;
    #1 chk("ret_dout0", dout0, 32'h1111_1111);
    cyc(); cs = 1'b0;
    #1 chk("ret_dout7", dout0, 32'h7777_7777);
    cyc(); cyc();

    // Deep sleep, then direct switch to shut-down through WAKE
    pwr_req = 2'b10;
    cyc(); cyc();
    #1 chk("ds_ack", {31'd0, pwr_ack0}, 32'd1);
    chk("ds_pins", {26'd0, u0.bank_ls, u0.bank_ds, u0.bank_sd}, {26'd0, 2'b00, 2'b11, 2'b00});
    pwr_req = 2'b11;
    cyc();
    #1 chk("sw_ack", {31'd0, pwr_ack0}, 32'd0);
    chk("sw_ds", {30'd0, u0.bank_ds}, 32'd0);
    cyc(); cyc();
    #1 chk("sw_act_ack", {31'd0, pwr_ack0}, 32'd0);
    chk("sw_act_ready", {31'd0, ready0}, 32'd0);
    cyc();
    #1 chk("sd_ack", {31'd0, pwr_ack0}, 32'd1);
    chk("sd_pins", {26'd0, u0.bank_ls, u0.bank_ds, u0.bank_sd}, {26'd0, 2'b00, 2'b00, 2'b11});
    pwr_req = 2'b00;
    cyc(); cyc(); cyc();
    #1 chk("sd_wake_ready", {31'd0, ready0}, 32'd1);
    wr(14'd1, 32'h5A5A_5A5A, 4'hF);
    cyc();

    // Reset while a read is in flight
    cs = 1'b1; we = 1'b0; addr = 14'd1;
    cyc(); cs = 1'b0; rst_n = 1'b0;
    #1 chk("mr_vld0", {31'd0, rsp_vld0}, 32'd0);
    chk("mr_dout0", dout0, 32'd0);
    chk("mr_vld1", {31'd0, rsp_vld1}, 32'd0);
    cyc(); rst_n = 1'b1;
    #1 chk("mr_vld1_b", {31'd0, rsp_vld1}, 32'd0);
    cyc();
    #1 chk("mr_ready", {31'd0, ready0}, 32'd1);
    chk("mr_ack", {31'd0, pwr_ack0}, 32'd0);
    chk("mr_vld0_after", {31'd0, rsp_vld0}, 32'd0);
    chk("mr_dout1", dout1, 32'd0);

    $display("protocol-error accesses driven: %0d", nproto);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
